// File: rtl/dram_uart_dump.sv
// Snapshots a 32x1 dual-port distributed RAM through its DPRA read port on a
// switch trigger and sends the 32 bits as a 5-byte 8N1 UART frame.
module dram_uart_dump #(
    parameter int          CLK_HZ = 100_000_000,
    parameter int          BAUD   = 115200,
    parameter logic [31:0] INIT   = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        tx,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("dram_uart_dump: CLK_HZ / BAUD must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SEND   = 2'd2
    } state_t;

    // RAM32X1D behaviour: synchronous write port, asynchronous SPO/DPO reads.
    // Contents are power-up initialised only; reset never touches them.
    logic [31:0] mem_q = INIT;
    logic        spo;
    logic        dpo;

    state_t      state_q;
    logic [4:0]  raddr_q;
    logic [31:0] snap_q;
    logic [2:0]  byte_idx_q;
    logic [3:0]  bit_idx_q;
    logic [CW-1:0] baud_q;
    logic        tx_q;
    logic [7:0]  last_byte_q;
    logic        s1_q;
    logic        s2_q;
    logic        s3_q;
    logic        trig;
    logic        busy;
    logic [7:0]  cur_byte;
    logic        unused_ok;

    always_ff @(posedge clk) begin
        if (sw[15]) begin
            mem_q[sw[4:0]] <= sw[13];
        end
    end

    assign spo = mem_q[sw[4:0]];
    assign dpo = mem_q[raddr_q];

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [31:0] s);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'hA5;
            3'd1:    b = s[7:0];
            3'd2:    b = s[15:8];
            3'd3:    b = s[23:16];
            default: b = s[31:24];
        endcase
        return b;
    endfunction

    assign trig     = s2_q & ~s3_q;
    assign busy     = (state_q != IDLE);
    assign cur_byte = frame_byte(byte_idx_q, snap_q);

    // bit_idx: 0 = start, 1..8 = data LSB first, 9 = stop. tx_q always holds
    // the level of the bit currently on the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            raddr_q     <= 5'd0;
            snap_q      <= 32'd0;
            byte_idx_q  <= 3'd0;
            bit_idx_q   <= 4'd0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
            last_byte_q <= 8'h00;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
        end else begin
            s1_q <= sw[14];
            s2_q <= s1_q;
            s3_q <= s2_q;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q <= SAMPLE;
                        raddr_q <= 5'd0;
                        snap_q  <= 32'd0;
                    end
                end
                SAMPLE: begin
                    snap_q[raddr_q] <= dpo;
                    raddr_q         <= raddr_q + 5'd1;
                    if (raddr_q == 5'd31) begin
                        state_q     <= SEND;
                        byte_idx_q  <= 3'd0;
                        bit_idx_q   <= 4'd0;
                        baud_q      <= '0;
                        tx_q        <= 1'b0;
                        last_byte_q <= 8'hA5;
                    end
                end
                SEND: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_idx_q == 4'd9) begin
                            if (byte_idx_q == 3'd4) begin
                                state_q <= IDLE;
                                tx_q    <= 1'b1;
                            end else begin
                                byte_idx_q  <= byte_idx_q + 3'd1;
                                bit_idx_q   <= 4'd0;
                                tx_q        <= 1'b0;
                                last_byte_q <= frame_byte(byte_idx_q + 3'd1, snap_q);
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            tx_q      <= (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx  = tx_q;
    assign led = {last_byte_q, raddr_q, busy, dpo, spo};

    assign unused_ok = ^{rx, sw[12:5]};

endmodule

// File: tb/tb_dram_uart_dump.sv
// Directed bench for dram_uart_dump at DIV=10: a mid-bit UART monitor collects
// frame bytes and each dump is compared with a hand-computed snapshot.
module tb_dram_uart_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        tx;
    logic [15:0] sw  = 16'h0000;
    logic [15:0] led;

    int errors = 0;
    int checks = 0;

    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    dram_uart_dump #(
        .CLK_HZ(1_000_000),
        .BAUD  (100_000),
        .INIT  (32'h0000_0002)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx (rx),
        .tx (tx),
        .sw (sw),
        .led(led)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART monitor: detects start bit, samples every bit at its midpoint
    int         mon_cnt = 0;
    bit         mon_active = 1'b0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % 10 == 5) begin
                if (mon_cnt / 10 == 0) begin
                    check("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_cnt / 10 <= 8) begin
                    mon_byte[mon_cnt / 10 - 1] = tx;
                end else begin
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    got_q.push_back({24'd0, mon_byte});
                    mon_active = 1'b0;
                end
            end
        end
    end

    // mode: 0 plain, 1 retrigger mid-SEND, 2 write addr31=1 in SAMPLE cycle 5,
    // 3 write addr0=0 in SAMPLE cycle 5, 4 hold trigger high for 100 cycles
    task automatic run_dump(input string name, input logic [31:0] snap, input int mode);
        int lat;
        int len;
        int extra;
        logic [31:0] v;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(32'hA5);
        exp_q.push_back({24'd0, snap[7:0]});
        exp_q.push_back({24'd0, snap[15:8]});
        exp_q.push_back({24'd0, snap[23:16]});
        exp_q.push_back({24'd0, snap[31:24]});
        check($sformatf("%s tx_idle_before", name), {31'd0, tx}, 32'd1);
        @(negedge clk);
        sw[14] = 1'b1;
        lat = 0;
        while (lat < 20 && led[2] == 1'b0) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("%s busy_seen", name), {31'd0, led[2]}, 32'd1);
        len = 0;
        while (len < 1000 && led[2] == 1'b1) begin
            if (mode != 4 && len == 0) sw[14] = 1'b0;
            if (mode == 4 && lat + len == 100) sw[14] = 1'b0;
            if (mode == 1 && len == 200) sw[14] = 1'b1;
            if (mode == 1 && len == 204) sw[14] = 1'b0;
            if (mode == 2 && len == 5) sw = 16'hA01F;
            if (mode == 3 && len == 5) sw = 16'h8000;
            if ((mode == 2 || mode == 3) && len == 6) sw = 16'h0000;
            @(negedge clk);
            len++;
        end
        sw = 16'h0000;
        check($sformatf("%s busy_len", name), len, 32'd532);
        check($sformatf("%s led_raddr_wrapped", name), {27'd0, led[7:3]}, 32'd0);
        check($sformatf("%s led_last_byte", name), {24'd0, led[15:8]}, exp_q[4]);
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (led[2] || !tx) extra++;
        end
        check($sformatf("%s quiet_after", name), extra, 32'd0);
        check($sformatf("%s frame_len", name), got_q.size(), 32'd5);
        for (int j = 0; j < 5; j++) begin
            v = (j < got_q.size()) ? got_q[j] : 32'hFFFF_FFFF;
            check($sformatf("%s byte%0d", name, j), v, exp_q[j]);
        end
    endtask

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic       d;
        logic       exp_spo;
    } wr_vec_t;

    wr_vec_t vecs[10];

    initial begin
        int lat;
        int len;

        vecs[0] = '{we: 1'b0, addr: 5'd1,  d: 1'b0, exp_spo: 1'b1};
        vecs[1] = '{we: 1'b0, addr: 5'd0,  d: 1'b0, exp_spo: 1'b0};
        vecs[2] = '{we: 1'b1, addr: 5'd0,  d: 1'b1, exp_spo: 1'b1};
        vecs[3] = '{we: 1'b1, addr: 5'd9,  d: 1'b1, exp_spo: 1'b1};
        vecs[4] = '{we: 1'b1, addr: 5'd31, d: 1'b1, exp_spo: 1'b1};
        vecs[5] = '{we: 1'b0, addr: 5'd2,  d: 1'b1, exp_spo: 1'b0};
        vecs[6] = '{we: 1'b0, addr: 5'd9,  d: 1'b0, exp_spo: 1'b1};
        vecs[7] = '{we: 1'b0, addr: 5'd31, d: 1'b0, exp_spo: 1'b1};
        vecs[8] = '{we: 1'b0, addr: 5'd0,  d: 1'b0, exp_spo: 1'b1};
        vecs[9] = '{we: 1'b0, addr: 5'd8,  d: 1'b1, exp_spo: 1'b0};

        // Reset state: DPO reads address 0, SPO follows sw[4:0]
        sw = 16'h0001;
        repeat (3) @(negedge clk);
        check("reset led addr1", {16'd0, led}, 32'h0001);
        check("reset tx", {31'd0, tx}, 32'd1);
        sw = 16'h0000;
        #1;
        check("reset led addr0", {16'd0, led}, 32'h0000);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("idle busy", {31'd0, led[2]}, 32'd0);

        run_dump("init", 32'h0000_0002, 0);

        for (int i = 0; i < 10; i++) begin
            sw = {vecs[i].we, 1'b0, vecs[i].d, 8'd0, vecs[i].addr};
            @(negedge clk);
            sw[15] = 1'b0;
            #1;
            check($sformatf("vec%0d spo", i), {31'd0, led[0]}, {31'd0, vecs[i].exp_spo});
            sw = 16'h0000;
        end

        run_dump("retrig", 32'h8000_0203, 1);

        // Reset in the middle of the third byte
        @(negedge clk);
        sw[14] = 1'b1;
        lat = 0;
        while (lat < 20 && led[2] == 1'b0) begin
            @(negedge clk);
            lat++;
        end
        sw[14] = 1'b0;
        check("midrst busy_seen", {31'd0, led[2]}, 32'd1);
        repeat (32 + 200 + 30) @(negedge clk);
        check("midrst pre busy", {31'd0, led[2]}, 32'd1);
        check("midrst pre last_byte", {24'd0, led[15:8]}, 32'h02);
        rst = 1'b1;
        #1;
        check("midrst tx", {31'd0, tx}, 32'd1);
        check("midrst busy", {31'd0, led[2]}, 32'd0);
        check("midrst led_hi", {24'd0, led[15:8]}, 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        run_dump("after_rst", 32'h8000_0203, 0);

        // Clear addr 31, then set it again while SAMPLE is at cycle 5
        sw = 16'h801F;
        @(negedge clk);
        sw[15] = 1'b0;
        #1;
        check("clr31 spo", {31'd0, led[0]}, 32'd0);
        sw = 16'h0000;
        run_dump("late_w31", 32'h8000_0203, 2);

        // Clearing addr 0 after it was sampled must not alter the snapshot
        run_dump("late_w0", 32'h8000_0203, 3);
        sw = 16'h0000;
        #1;
        check("addr0 cleared spo", {31'd0, led[0]}, 32'd0);

        run_dump("hold100", 32'h8000_0202, 4);

        len = 0;
        repeat (20) begin
            @(negedge clk);
            if (led[2]) len++;
        end
        check("final idle", len, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
